// File: rtl/pack_feeder_pkg.sv
// Shared types and helpers for the multi-pack bot-index provider.
package pack_feeder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   function automatic int idx_width(input int memsize);
      return (memsize > 1) ? $clog2(memsize) : 1;
   endfunction

   function automatic logic below_threshold(input logic [31:0] fullness, input int threshold);
      return fullness < 32'(threshold);
   endfunction

endpackage

// File: rtl/index_tag_fifo.sv
// Synchronous tag FIFO with first-word-fall-through head; holds indices issued to one pack.
module index_tag_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [AW:0]      count_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
         else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/multi_pack_index_provider.sv
// Round-robin bot-index issuer for NUM_PACKS pipeline packs with per-pack tag FIFOs.
// Optional soak mode (index wrap, saturating counts) enabled by defining PACK_FEEDER_WRAP_EN.
module multi_pack_index_provider
   import pack_feeder_pkg::*;
#(
   parameter int MEMSIZE        = 16384,
   parameter int NUM_PACKS      = 4,
   parameter int FULLNESS_W     = 5,
   parameter int FULL_THRESHOLD = 30,
   parameter int TAG_DEPTH      = 64,
   localparam int IDX_W         = idx_width(MEMSIZE)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            stop,
   input  logic [NUM_PACKS*FULLNESS_W-1:0] pack_fullness,
   input  logic [NUM_PACKS-1:0]            result_valid,
   output logic [IDX_W-1:0]                index,
   output logic [NUM_PACKS-1:0]            index_valid,
   output logic [NUM_PACKS*IDX_W-1:0]      result_index,
   output logic [IDX_W:0]                  issued_count,
   output logic [IDX_W:0]                  retired_count,
   output logic                            busy,
   output logic                            done,
   output logic                            tag_underflow
);

`ifdef PACK_FEEDER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam int PTR_W = (NUM_PACKS > 1) ? $clog2(NUM_PACKS) : 1;
   localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEMSIZE - 1);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       next_idx_q, next_idx_d, index_q, index_d;
   logic [NUM_PACKS-1:0]   index_valid_q, index_valid_d;
   logic [PTR_W-1:0]       rr_q, rr_d;
   logic [IDX_W:0]         issued_q, issued_d, retired_q, retired_d;
   logic                   underflow_q, underflow_d;

   logic [NUM_PACKS-1:0]   eligible, grant, tag_empty, tag_full, pop;
   logic [CNT_W-1:0]       tag_count [NUM_PACKS];
   logic                   grant_any, last_issue;
   logic [PTR_W-1:0]       grant_idx;
   logic [IDX_W:0]         pop_cnt;
   logic [IDX_W+1:0]       retired_sum;
   int                     arb_p;

   for (genvar gi = 0; gi < NUM_PACKS; gi++) begin : g_pack
      index_tag_fifo #(.WIDTH(IDX_W), .DEPTH(TAG_DEPTH)) u_fifo (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .push_i      (index_valid_q[gi]),
         .push_data_i (index_q),
         .pop_i       (pop[gi]),
         .head_o      (result_index[gi*IDX_W +: IDX_W]),
         .count_o     (tag_count[gi]),
         .empty_o     (tag_empty[gi]),
         .full_o      (tag_full[gi])
      );
      assign pop[gi] = result_valid[gi] & ~tag_empty[gi];
      // The issue granted last cycle is pushed this cycle, so it already occupies a slot.
      assign eligible[gi] = (state_q == RUN)
                          && below_threshold(32'(pack_fullness[gi*FULLNESS_W +: FULLNESS_W]), FULL_THRESHOLD)
                          && !tag_full[gi]
                          && !(index_valid_q[gi] && (tag_count[gi] == CNT_W'(TAG_DEPTH - 1)));
   end

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      arb_p     = 0;
      for (int k = 0; k < NUM_PACKS; k++) begin
         arb_p = (int'(rr_q) + k) % NUM_PACKS;
         if (!grant_any && eligible[arb_p]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(arb_p);
         end
      end
      grant = grant_any ? (NUM_PACKS'(1) << grant_idx) : '0;
   end

   always_comb begin
      pop_cnt = '0;
      for (int k = 0; k < NUM_PACKS; k++) pop_cnt = pop_cnt + {{IDX_W{1'b0}}, pop[k]};
   end

   assign retired_sum = {1'b0, retired_q} + {1'b0, pop_cnt};
   assign last_issue  = !WRAP && grant_any && (next_idx_q == LAST_IDX);

   always_comb begin
      state_d       = state_q;
      next_idx_d    = next_idx_q;
      index_d       = index_q;
      index_valid_d = '0;
      rr_d          = rr_q;
      issued_d      = issued_q;
      retired_d     = (WRAP && retired_sum[IDX_W+1]) ? '1 : retired_sum[IDX_W:0];
      underflow_d   = underflow_q | (|(result_valid & tag_empty));
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               next_idx_d = '0;
               index_d    = '0;
               issued_d   = '0;
               retired_d  = '0;
            end
         end
         RUN:     if (stop || last_issue) state_d = DRAIN;
         DRAIN:   if ((&tag_empty) && (index_valid_q == '0)) state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (grant_any) begin
         index_valid_d = grant;
         index_d       = next_idx_q;
         next_idx_d    = (WRAP && next_idx_q == LAST_IDX) ? '0 : next_idx_q + IDX_W'(1);
         issued_d      = (WRAP && (&issued_q)) ? issued_q : issued_q + (IDX_W+1)'(1);
         rr_d          = (grant_idx == PTR_W'(NUM_PACKS - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         next_idx_q    <= '0;
         index_q       <= '0;
         index_valid_q <= '0;
         rr_q          <= '0;
         issued_q      <= '0;
         retired_q     <= '0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         next_idx_q    <= next_idx_d;
         index_q       <= index_d;
         index_valid_q <= index_valid_d;
         rr_q          <= rr_d;
         issued_q      <= issued_d;
         retired_q     <= retired_d;
         underflow_q   <= underflow_d;
      end
   end

   assign index         = index_q;
   assign index_valid   = index_valid_q;
   assign issued_count  = issued_q;
   assign retired_count = retired_q;
   assign busy          = (state_q == RUN) || (state_q == DRAIN);
   assign done          = (state_q == DONE);
   assign tag_underflow = underflow_q;

endmodule

// File: tb/tb_multi_pack_index_provider.sv
// Scoreboard bench: expected issues queued by stimulus, checked by a negedge monitor that also returns results.
module tb_multi_pack_index_provider;

   localparam int MEMSIZE = 1024;
   localparam int NP      = 4;
   localparam int FW      = 5;
   localparam int IW      = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, stop;
   logic [NP*FW-1:0]  pack_fullness;
   logic [NP-1:0]     result_valid;
   logic [IW-1:0]     index;
   logic [NP-1:0]     index_valid;
   logic [NP*IW-1:0]  result_index;
   logic [IW:0]       issued_count, retired_count;
   logic              busy, done, tag_underflow;

   multi_pack_index_provider #(
      .MEMSIZE(MEMSIZE), .NUM_PACKS(NP), .FULLNESS_W(FW), .FULL_THRESHOLD(30), .TAG_DEPTH(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .pack_fullness(pack_fullness), .result_valid(result_valid),
      .index(index), .index_valid(index_valid), .result_index(result_index),
      .issued_count(issued_count), .retired_count(retired_count),
      .busy(busy), .done(done), .tag_underflow(tag_underflow)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; int pack; } iss_t;
   iss_t      exp_q[$];
   int        tag_q [NP][$];
   int        checks = 0;
   int        errors = 0;
   int        obs_issues = 0;
   int        exp_retired = 0;
   bit        exp_underflow = 0;
   int        ret_mode = 0;        // 0 none, 1 echo issues 8 cycles later, 2 drain
   logic [NP-1:0] pulse_mask = '0;
   logic [NP-1:0] dline [8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: returns results to the DUT and checks every issue against the expected queue.
   initial begin
      logic [NP-1:0] rv;
      iss_t e;
      result_valid = '0;
      for (int k = 0; k < 8; k++) dline[k] = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int k = 0; k < 8; k++) dline[k] = '0;
            result_valid = '0;
            continue;
         end
         rv = pulse_mask;
         pulse_mask = '0;
         if (ret_mode == 1) rv = rv | dline[7];
         else if (ret_mode == 2)
            for (int p = 0; p < NP; p++) if (tag_q[p].size() > 0) rv[p] = 1'b1;
         for (int k = 7; k > 0; k--) dline[k] = dline[k-1];
         dline[0] = index_valid;
         for (int p = 0; p < NP; p++) begin
            if (rv[p]) begin
               if (tag_q[p].size() > 0) begin
                  check($sformatf("result_index[%0d]", p), int'(result_index[p*IW +: IW]), tag_q[p].pop_front());
                  exp_retired++;
               end else exp_underflow = 1'b1;
            end
         end
         result_valid = rv;
         if (index_valid != '0) begin
            obs_issues++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: index %0d to packs %b, expected no issue", index, index_valid);
            end else begin
               e = exp_q.pop_front();
               check("issue_pack", int'(index_valid), 1 << e.pack);
               check("issue_index", int'(index), e.idx);
               tag_q[e.pack].push_back(e.idx);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic pulse_start();
      obs_issues = 0;
      exp_retired = 0;
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (!done && n < limit) begin tick(1); n++; end
      check("done_reached", int'(done), 1);
   endtask

   task automatic wait_obs(input int target, input int limit);
      int n = 0;
      while (obs_issues < target && n < limit) begin tick(1); n++; end
      check("issues_observed", obs_issues >= target ? target : obs_issues, target);
   endtask

   initial begin
      int pat [3];
      pat[0] = 0; pat[1] = 2; pat[2] = 3;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; pack_fullness = '0;
      tick(3);
      check("rst_index", int'(index), 0);
      check("rst_index_valid", int'(index_valid), 0);
      check("rst_issued", int'(issued_count), 0);
      check("rst_retired", int'(retired_count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_underflow", int'(tag_underflow), 0);
      rst_n = 1'b1;
      tick(2);
      check("idle_busy", int'(busy), 0);

      // Run 1: all packs open, results echoed after 8 cycles
      ret_mode = 1;
      for (int i = 0; i < MEMSIZE; i++) exp_q.push_back('{i, i % NP});
      pulse_start();
      check("run1_busy", int'(busy), 1);
      wait_done(3000);
      check("run1_issued", int'(issued_count), MEMSIZE);
      check("run1_retired", int'(retired_count), MEMSIZE);
      check("run1_retired_model", int'(retired_count), exp_retired);
      check("run1_all_seen", exp_q.size(), 0);
      check("run1_busy_end", int'(busy), 0);

      // Run 2: pack 1 held at threshold, then released
      pack_fullness = (NP*FW)'(30) << FW;
      for (int i = 0; i < MEMSIZE; i++)
         exp_q.push_back('{i, (i <= 31) ? pat[i % 3] : (i - 31 + 2) % NP});
      pulse_start();
      wait_obs(32, 200);
      pack_fullness = '0;
      wait_done(3000);
      check("run2_issued", int'(issued_count), MEMSIZE);
      check("run2_retired", int'(retired_count), MEMSIZE);
      check("run2_all_seen", exp_q.size(), 0);

      // Run 3: no results, FIFOs fill; one pop on pack 2 admits one issue
      ret_mode = 0;
      for (int i = 0; i < 256; i++) exp_q.push_back('{i, (i + 3) % NP});
      pulse_start();
      wait_obs(256, 600);
      tick(20);
      check("full_issued", int'(issued_count), 256);
      check("full_no_issue", int'(index_valid), 0);
      check("full_busy", int'(busy), 1);
      exp_q.push_back('{256, 2});
      pulse_mask = 4'b0100;
      wait_obs(257, 50);
      tick(10);
      check("pop2_issued", int'(issued_count), 257);
      check("pop2_retired", int'(retired_count), 1);
      stop = 1'b1; tick(1); stop = 1'b0;
      tick(3);
      ret_mode = 2;
      wait_done(500);
      ret_mode = 0;
      check("run3_retired", int'(retired_count), 257);
      check("run3_all_seen", exp_q.size(), 0);

      // Underflow: pack 3 result with its FIFO empty
      pulse_mask = 4'b1000;
      tick(3);
      check("underflow_set", int'(tag_underflow), 1);
      check("underflow_model", int'(tag_underflow), int'(exp_underflow));
      check("underflow_retired", int'(retired_count), 257);

      // Run 5: stop after 100 issues, drain
      ret_mode = 1;
      for (int i = 0; i < 100; i++) exp_q.push_back('{i, (i + 3) % NP});
      pulse_start();
      check("start_keeps_underflow", int'(tag_underflow), 1);
      check("start_clears_issued", int'(issued_count), 0);
      check("start_clears_retired", int'(retired_count), 0);
      begin
         int n = 0;
         while (obs_issues < 99 && n < 300) begin tick(1); n++; end
      end
      stop = 1'b1; tick(1); stop = 1'b0;
      wait_done(300);
      tick(12);
      check("stop_issued", int'(issued_count), 100);
      check("stop_retired", int'(retired_count), 100);
      check("stop_all_seen", exp_q.size(), 0);

      // Run 6: asynchronous reset mid-run
      for (int i = 0; i < MEMSIZE; i++) exp_q.push_back('{i, (i + 3) % NP});
      pulse_start();
      tick(20);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", int'(index_valid), 0);
      check("midrst_issued", int'(issued_count), 0);
      check("midrst_retired", int'(retired_count), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_underflow", int'(tag_underflow), 0);
      exp_q.delete();
      for (int p = 0; p < NP; p++) tag_q[p].delete();
      exp_underflow = 1'b0;
      ret_mode = 0;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check("post_rst_idle", int'(busy), 0);
      check("post_rst_done", int'(done), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
